wdgrv_svc_master: RTL

//  Hardware service agent for the WdgRV watchdog. It is the bus initiator on the

---
 rtl/wdgrv_svc_master.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wdgrv_svc_master.sv
// Purpose: service agent for the WdgRV watchdog. It arms the watchdog, then polls WDCSR and kicks WDCNT each period, and it also disarms.
// Latency: a request is raised one cycle after its state is entered, and o_req drops the cycle after i_ack is sampled.
// Backpressure: o_req and its fields are held until i_ack. After ACK_TIMEOUT wait cycles the request is aborted (o_bus_err).
module wdgrv_svc_master #(
  parameter int KICK_PERIOD = 1000,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cfg_start,
  input  logic [9:0]  i_cfg_wtocnt,
  input  logic        i_stop,
  output logic        o_req,
  output logic        o_write,
  output logic [2:0]  o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_strb,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic        o_armed,
  output logic        o_busy,
  output logic [31:0] o_csr_snap,
  output logic        o_s1wto,
  output logic        o_s2wto,
  output logic        o_bus_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CFG_WR  = 3'd1;
  localparam logic [2:0] S_ARMED   = 3'd2;
  localparam logic [2:0] S_POLL_RD = 3'd3;
  localparam logic [2:0] S_KICK_WR = 3'd4;
  localparam logic [2:0] S_STOP_WR = 3'd5;

  localparam int PER_W  = $clog2(KICK_PERIOD);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(KICK_PERIOD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  logic [2:0]        state_q, state_d, next_s;
  logic              req_q, req_d;
  logic              write_q, write_d;
  logic [2:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              armed_q, armed_d;
  logic [31:0]       snap_q, snap_d;
  logic              bus_err_q, bus_err_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [9:0]        wto_q, wto_d;
  logic              pend_stop_q, pend_stop_d;
  logic              pend_start_q, pend_start_d;
  logic [9:0]        pend_wto_q, pend_wto_d;

  // A command seen this cycle merges with one that is already pending.
  // The wtocnt of the newest start wins.
  logic       cmd_stop, cmd_start;
  logic [9:0] cmd_wto;
  assign cmd_stop  = pend_stop_q | i_stop;
  assign cmd_start = pend_start_q | i_cfg_start;
  assign cmd_wto   = i_cfg_start ? i_cfg_wtocnt : pend_wto_q;

  // Next-state logic for the sequencer, the bus request and the pending commands.
  always_comb begin
    state_d      = state_q;
    next_s       = S_IDLE;
    req_d        = req_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    armed_d      = armed_q;
    snap_d       = snap_q;
    bus_err_d    = 1'b0;
    per_d        = per_q;
    wait_d       = wait_q;
    wto_d        = wto_q;
    pend_stop_d  = pend_stop_q;
    pend_start_d = pend_start_q;
    pend_wto_d   = pend_wto_q;

    case (state_q)
      S_IDLE: begin
        pend_stop_d  = 1'b0;
        pend_start_d = 1'b0;
        if (i_stop) begin
          state_d = S_STOP_WR;
        end else if (i_cfg_start) begin
          state_d = S_CFG_WR;
          wto_d   = i_cfg_wtocnt;
        end
      end

      S_ARMED: begin
        if (cmd_stop) begin
          state_d      = S_STOP_WR;
          pend_stop_d  = 1'b0;
          pend_start_d = 1'b0;
        end else if (cmd_start) begin
          state_d      = S_CFG_WR;
          wto_d        = cmd_wto;
          pend_start_d = 1'b0;
        end else if (per_q == PER_LAST) begin
          state_d = S_POLL_RD;
        end else begin
          per_d = per_q + 1'b1;
        end
      end

      S_CFG_WR, S_POLL_RD, S_KICK_WR, S_STOP_WR: begin
        // Commands that arrive mid-transaction wait for the ack.
        if (i_stop) pend_stop_d = 1'b1;
        if (i_cfg_start) begin
          pend_start_d = 1'b1;
          pend_wto_d   = i_cfg_wtocnt;
        end

        if (!req_q) begin
          // Issue the transaction for this state.
          req_d  = 1'b1;
          wait_d = '0;
          case (state_q)
            S_CFG_WR: begin
              write_d = 1'b1; addr_d = 3'h0; strb_d = 4'hF;
              wdata_d = {18'b0, wto_q, 2'b00, 1'b0, 1'b1};
            end
            S_POLL_RD: begin
              write_d = 1'b0; addr_d = 3'h0; strb_d = 4'h0; wdata_d = 32'h0;
            end
            S_KICK_WR: begin
              write_d = 1'b1; addr_d = 3'h4; strb_d = 4'hF; wdata_d = 32'h0;
            end
            default: begin
              write_d = 1'b1; addr_d = 3'h0; strb_d = 4'hF;
              wdata_d = {18'b0, wto_q, 4'b0000};
            end
          endcase
        end else if (i_ack) begin
          req_d   = 1'b0;
          write_d = 1'b0;
          addr_d  = 3'h0;
          wdata_d = 32'h0;
          strb_d  = 4'h0;
          wait_d  = '0;
          per_d   = '0;
          case (state_q)
            S_CFG_WR: begin
              armed_d = 1'b1;
              next_s  = S_ARMED;
            end
            S_POLL_RD: begin
              snap_d = i_rdata;
              if (i_rdata[3]) begin
                armed_d = 1'b0;
                next_s  = S_IDLE;
              end else begin
                next_s  = S_KICK_WR;
              end
            end
            S_KICK_WR: next_s = S_ARMED;
            default: begin
              armed_d = 1'b0;
              next_s  = S_IDLE;
            end
          endcase
          // A pending stop beats a pending start. Executing either command clears both.
          if (cmd_stop) begin
            state_d      = S_STOP_WR;
            pend_stop_d  = 1'b0;
            pend_start_d = 1'b0;
          end else if (cmd_start) begin
            state_d      = S_CFG_WR;
            wto_d        = cmd_wto;
            pend_start_d = 1'b0;
          end else begin
            state_d = next_s;
          end
        end else if (wait_q == WAIT_LAST) begin
          // The slave has not answered in time: abandon the transaction and everything queued.
          req_d        = 1'b0;
          write_d      = 1'b0;
          addr_d       = 3'h0;
          wdata_d      = 32'h0;
          strb_d       = 4'h0;
          wait_d       = '0;
          bus_err_d    = 1'b1;
          armed_d      = 1'b0;
          pend_stop_d  = 1'b0;
          pend_start_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset. A reset mid-transaction simply drops o_req.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 3'h0;
      wdata_q      <= 32'h0;
      strb_q       <= 4'h0;
      armed_q      <= 1'b0;
      snap_q       <= 32'h0;
      bus_err_q    <= 1'b0;
      per_q        <= '0;
      wait_q       <= '0;
      wto_q        <= 10'h0;
      pend_stop_q  <= 1'b0;
      pend_start_q <= 1'b0;
      pend_wto_q   <= 10'h0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      armed_q      <= armed_d;
      snap_q       <= snap_d;
      bus_err_q    <= bus_err_d;
      per_q        <= per_d;
      wait_q       <= wait_d;
      wto_q        <= wto_d;
      pend_stop_q  <= pend_stop_d;
      pend_start_q <= pend_start_d;
      pend_wto_q   <= pend_wto_d;
    end
  end

  assign o_req      = req_q;
  assign o_write    = write_q;
  assign o_addr     = addr_q;
  assign o_wdata    = wdata_q;
  assign o_strb     = strb_q;
  assign o_armed    = armed_q;
  assign o_busy     = (state_q != S_IDLE) && (state_q != S_ARMED);
  assign o_csr_snap = snap_q;
  assign o_s1wto    = snap_q[2];
  assign o_s2wto    = snap_q[3];
  assign o_bus_err  = bus_err_q;

endmodule
